prog_mem_arbiter: RTL

//  Shares the single-port program memory between the core instruction fetch

---
 rtl/prog_mem_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/prog_mem_arbiter.sv
// Program memory arbiter: fixed-priority loader port with a burst limiter so
// that instruction fetch always makes progress; read data is steered back to its issuer.
module prog_mem_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_LD_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_gnt,
  output logic                  ld_rvalid,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // owner state | meaning
  // OWN_NONE    | no read issued last cycle, both rvalid low
  // OWN_IF      | fetch read issued last cycle, mem_rdata belongs to IF
  // OWN_LD      | loader read issued last cycle, mem_rdata belongs to LD
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LD} owner_e;

  localparam int RUN_W = $clog2(MAX_LD_BURST + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_LD_BURST);

  owner_e           owner_q, owner_d;
  logic [RUN_W-1:0] ld_run_q, ld_run_d;
  logic             ld_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      ld_run_q <= '0;
    end else begin
      owner_q  <= owner_d;
      ld_run_q <= ld_run_d;
    end
  end

  always_comb begin
    ld_win    = ld_req && !(if_req && (ld_run_q == RUN_MAX));
    ld_gnt    = !rst && ld_win;
    if_gnt    = !rst && if_req && !ld_win;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (ld_gnt) begin
      mem_addr  = ld_addr;
      mem_we    = ld_we;
      mem_wdata = ld_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  // Burst count only matters while fetch is waiting, so any idle-fetch cycle resets it.
  always_comb begin
    ld_run_d = ld_run_q;
    if (!if_req || if_gnt) begin
      ld_run_d = '0;
    end else if (ld_gnt && (ld_run_q != RUN_MAX)) begin
      ld_run_d = ld_run_q + RUN_W'(1);
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (ld_gnt && !ld_we) begin
      owner_d = OWN_LD;
    end else if (if_gnt) begin
      owner_d = OWN_IF;
    end
  end

  always_comb begin
    if_rvalid = (owner_q == OWN_IF);
    ld_rvalid = (owner_q == OWN_LD);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    ld_rdata  = ld_rvalid ? mem_rdata : '0;
  end

endmodule
